dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Parametrised data-memory controller for the MIPS datapath.
- Adds synchronous byte/half/word access with sign or zero extension on loads.
- Uses a valid/ready request channel with configurable fixed latency.
- Flags misaligned accesses.
- Sits between the MEM stage and the word-array storage; the pipeline stalls while req_ready=0.

Parameters:
ADDR_W, 32, byte-address width
DEPTH, 8192, number of 32-bit words; must be a power of 2
LATENCY, 1, cycles from request accept to rsp_valid; legal 1..4

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  loads only: 1=zero-extend (lbu/lhu), 0=sign-extend
addr  in  ADDR_W  byte address
wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle pulse, response available
rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  qualified by rsp_valid; misaligned or reserved size

Behaviour:
Reset:
- State goes to IDLE.
- req_ready=1, rsp_valid=0, rdata=0, rsp_err=0, latency counter=0.
- Memory contents are not cleared.
- A reset during BUSY aborts the operation. No response is issued. A store already committed at accept stays committed.

Byte ordering and indexing:
- Little-endian. Byte lane k = addr[1:0] maps to bits [8k+7:8k].
- Word index = addr[2+log2(DEPTH)-1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH words.

Errors:
- req_size=11 is an error.
- Half access with addr[0]=1 is an error.
- Word access with addr[1:0]!=00 is an error.
- An erroring request never modifies memory.

State machine, two states:
- IDLE: req_ready=1. A request is accepted on an edge where req_valid=1.
  - Store, no error: byte-enabled write commits on that same edge.
  - Load, no error: the addressed word is captured into a holding register on that edge.
  - The error flag is captured on that edge.
  - Counter is loaded with LATENCY-1.
  - If LATENCY=1, go to RESP. Otherwise go to BUSY.
- BUSY: req_ready=0. Counter decrements each cycle. When the counter reaches 1, go to RESP on the next edge.
- RESP is a single cycle, implemented as a registered pulse asserted on entry to IDLE:
  - rsp_valid=1 for exactly one cycle, LATENCY cycles after the accept edge.
  - req_ready=1 in the same cycle, so back-to-back throughput is one request per LATENCY cycles.
  - Any request presented while req_ready=0 is ignored; the requester must hold it.

Load extension (applied to the holding register at response time):
- Byte: lane selected by captured addr[1:0]; bit 7 extended, or zeros if req_unsigned.
- Half: lane selected by captured addr[1]; bit 15 extended, or zeros if req_unsigned.
- Word: passed through unchanged.
- rdata is held at its value between responses. It is 0 on any store or error response.

Hazards:
- A load issued immediately after a store to the same word sees the stored data, because the store committed at its own accept edge.

Optional Feature:
- DMEM_BOUNDS_CHECK_EN defined:
  - Any address with nonzero bits above bit 2+log2(DEPTH)-1 is an error: rsp_err=1, no write, rdata=0.
- DMEM_BOUNDS_CHECK_EN undefined:
  - No bounds check; addresses wrap as described under Behaviour.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - the state encoding
  - a function computing the byte-enable mask from size and addr[1:0]
- One natural sub-module, dmem_load_ext: purely combinational lane select plus sign/zero extension from (word, size, addr[1:0], unsigned).

Test Plan:
- Reset, then word store 0xDEADBEEF at addr 0x10, then word load from 0x10 with LATENCY=1 -> rsp_valid one cycle after each accept; rdata=0xDEADBEEF, rsp_err=0.
- Word at 0x10=0xDEADBEEF; lb at 0x13 -> 0xFFFFFFDE; lbu at 0x13 -> 0x000000DE; lh at 0x10 -> 0xFFFFBEEF; lhu at 0x12 -> 0x0000DEAD.
- sb 0x55 to 0x11 over 0xDEADBEEF, then word load 0x10 -> 0xDEAD55EF. sh at 0x11 -> rsp_err=1 and the word remains 0xDEAD55EF.
- LATENCY=3, req_valid held high for 6 cycles -> req_ready low for 2 cycles after each accept; rsp_valid exactly 3 cycles after each accept; two requests accepted.
- DEPTH=8192 without the macro: store 0x1234 to 0x8010, load 0x0010 -> 0x00001234. With DMEM_BOUNDS_CHECK_EN: same store -> rsp_err=1 and the load returns the old value.
- LATENCY=4: load accepted, reset asserted in the second BUSY cycle -> no rsp_valid; req_ready=1 the cycle after reset; prior memory contents intact.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the data-memory controller.
// Optional bounds check in dmem_ctrl is enabled by DMEM_BOUNDS_CHECK_EN.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lo;
    logic       err;
  } dmem_req_t;

  function automatic logic [3:0] be_mask(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      size == SZ_BYTE: m = 4'b0001 << lo;
      size == SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      size == SZ_WORD: m = 4'b1111;
      default:         m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic size_err(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic e;
    e = 1'b0;
    unique case (1'b1)
      size == SZ_RSVD: e = 1'b1;
      size == SZ_HALF: e = lo[0];
      size == SZ_WORD: e = |lo;
      default:         e = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: valid/ready request channel and response pulse of dmem_ctrl.
// master = MEM stage, slave = controller.
interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic [31:0]       rdata;
  logic              rsp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_size,
    output req_unsigned,
    output addr,
    output wdata,
    input  req_ready,
    input  rsp_valid,
    input  rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_size,
    input  req_unsigned,
    input  addr,
    input  wdata,
    output req_ready,
    output rsp_valid,
    output rdata,
    output rsp_err
  );
endinterface

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: lane select plus sign/zero extension of a loaded word.
// Purely combinational.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{lo, 3'b000} +: 8];
    h    = lo[1] ? word[31:16] : word[15:0];
    data = '0;
    unique case (1'b1)
      size == SZ_BYTE: data = {{24{b[7] & ~uns}}, b};
      size == SZ_HALF: data = {{16{h[15] & ~uns}}, h};
      size == SZ_WORD: data = word;
      default:         data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte/half/word data memory with fixed-latency valid/ready port.
// Define DMEM_BOUNDS_CHECK_EN to flag addresses beyond DEPTH words.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 1
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  localparam int         IW       = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
  localparam bit         LAT1     = (LATENCY == 1);

  logic [31:0] mem [DEPTH];

  logic [0:0]  state;
  logic [2:0]  cnt;
  dmem_req_t   cur;
  dmem_req_t   hold;
  dmem_req_t   src;
  logic [31:0] hold_w;
  logic [31:0] rd_w;
  logic [31:0] src_w;
  logic [31:0] ext_w;
  logic [31:0] rsp_w;
  logic [31:0] wd;
  logic [IW-1:0] idx;
  logic [3:0]  be;
  logic        oob;
  logic        accept;
  logic        we;
  logic        rv_q;
  logic        err_q;
  logic [31:0] rdata_q;

  assign idx = bus.addr[IW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
  if (ADDR_W > IW + 2) begin : g_oob
    assign oob = |bus.addr[ADDR_W-1:IW+2];
  end else begin : g_no_oob
    assign oob = 1'b0;
  end
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    cur.write = bus.req_write;
    cur.size  = bus.req_size;
    cur.uns   = bus.req_unsigned;
    cur.lo    = bus.addr[1:0];
    cur.err   = size_err(bus.req_size, bus.addr[1:0]) | oob;
  end

  assign accept = (state == ST_IDLE) & bus.req_valid;
  assign we     = accept & ~reset & cur.write & ~cur.err;
  assign be     = be_mask(cur.size, cur.lo);
  assign rd_w   = mem[idx];

  // Replicate store data across lanes so the byte enables pick it up.
  always_comb begin
    wd = bus.wdata;
    unique case (1'b1)
      cur.size == SZ_BYTE: wd = {4{bus.wdata[7:0]}};
      cur.size == SZ_HALF: wd = {2{bus.wdata[15:0]}};
      default:             wd = bus.wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wd[8*k +: 8];
      end
    end
  end

  // With LATENCY=1 the response is built from the live request and array.
  assign src   = LAT1 ? cur  : hold;
  assign src_w = LAT1 ? rd_w : hold_w;

  dmem_load_ext u_ext (
    .word (src_w),
    .size (src.size),
    .lo   (src.lo),
    .uns  (src.uns),
    .data (ext_w)
  );

  assign rsp_w = (src.write | src.err) ? 32'h0 : ext_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      hold    <= '0;
      hold_w  <= '0;
    end else begin
      rv_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            hold   <= cur;
            hold_w <= rd_w;
            cnt    <= CNT_INIT;
            if (LAT1) begin
              rv_q    <= 1'b1;
              err_q   <= cur.err;
              rdata_q <= rsp_w;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state   <= ST_IDLE;
            rv_q    <= 1'b1;
            err_q   <= hold.err;
            rdata_q <= rsp_w;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rv_q;
  assign bus.rdata     = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl at LATENCY 1, 3 and 4.
// Honours DMEM_BOUNDS_CHECK_EN in its reference model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic        vld;
  logic        wr;
  logic        uns;
  logic [1:0]  sz;
  logic [31:0] a;
  logic [31:0] wd;
  int          sel;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  logic [2:0]  rdy;
  logic [2:0]  rv;
  logic [2:0]  re;
  logic [31:0] rd [3];

  always @(posedge clk) cyc <= cyc + 1;

  dmem_if #(.ADDR_W(32)) b [3] ();

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    assign b[gi].req_valid    = vld && (sel == gi);
    assign b[gi].req_write    = wr;
    assign b[gi].req_size     = sz;
    assign b[gi].req_unsigned = uns;
    assign b[gi].addr         = a;
    assign b[gi].wdata        = wd;
    assign rdy[gi]            = b[gi].req_ready;
    assign rv[gi]             = b[gi].rsp_valid;
    assign re[gi]             = b[gi].rsp_err;
    assign rd[gi]             = b[gi].rdata;

    dmem_ctrl #(
      .ADDR_W  (32),
      .DEPTH   (8192),
      .LATENCY (gi == 0 ? 1 : (gi == 1 ? 3 : 4))
    ) u_dut (
      .clk   (clk),
      .reset (rst[gi]),
      .bus   (b[gi])
    );
  end

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          acc;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];
  sb_t q2[$];

  logic [31:0] mm [3][8192];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat(input int i);
    return i == 0 ? 1 : (i == 1 ? 3 : 4);
  endfunction

  function automatic int qsz(input int i);
    if (i == 0) return q0.size();
    if (i == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic sb_t qpop(input int i);
    if (i == 0) return q0.pop_front();
    if (i == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  task automatic qpush(input int i, input sb_t e);
    if (i == 0) q0.push_back(e);
    else if (i == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  function automatic logic m_err(input logic [1:0] z, input logic [31:0] ad);
    logic e;
    e = (z == 2'd3) || (z == 2'd1 && ad[0]) || (z == 2'd2 && ad[1:0] != 2'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
    e = e || (ad[31:15] != 17'd0);
`endif
    return e;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] w,
      input logic [1:0] z, input logic [1:0] lo, input logic u);
    logic [31:0] r;
    if (z == 2'd0) begin
      r = (w >> (8 * lo)) & 32'hFF;
      if (!u && r[7]) r = r | 32'hFFFFFF00;
    end else if (z == 2'd1) begin
      r = (w >> (16 * lo[1])) & 32'hFFFF;
      if (!u && r[15]) r = r | 32'hFFFF0000;
    end else begin
      r = w;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_st(input logic [31:0] old,
      input logic [1:0] z, input logic [1:0] lo, input logic [31:0] d);
    logic [31:0] m;
    if (z == 2'd0) m = 32'hFF << (8 * lo);
    else if (z == 2'd1) m = 32'hFFFF << (16 * lo[1]);
    else m = 32'hFFFFFFFF;
    return (old & ~m) | ((d << (8 * lo)) & m);
  endfunction

  task automatic wait_rdy(input int s);
    int n = 0;
    while (!rdy[s] && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic sb_t model(input int s, input logic w,
      input logic [1:0] z, input logic u, input logic [31:0] ad,
      input logic [31:0] d);
    sb_t e;
    logic [12:0] ix;
    ix    = ad[14:2];
    e.e   = m_err(z, ad);
    e.acc = cyc + 1;
    if (w) begin
      e.d = 32'h0;
      if (!e.e) mm[s][ix] = m_st(mm[s][ix], z, ad[1:0], d);
    end else begin
      e.d = e.e ? 32'h0 : m_ext(mm[s][ix], z, ad[1:0], u);
    end
    return e;
  endfunction

  task automatic issue(input int s, input logic w, input logic [1:0] z,
      input logic u, input logic [31:0] ad, input logic [31:0] d);
    sel = s; wr = w; sz = z; uns = u; a = ad; wd = d;
    wait_rdy(s);
    if (!rdy[s]) begin
      chk("accept_timeout", {31'd0, rdy[s]}, 32'd1);
      return;
    end
    vld = 1'b1;
    qpush(s, model(s, w, z, u, ad, d));
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
  endtask

  always @(negedge clk) begin
    sb_t e;
    for (int i = 0; i < 3; i++) begin
      if (rv[i]) begin
        if (qsz(i) == 0) begin
          chk($sformatf("unexpected_rsp%0d", i), 32'd1, 32'd0);
        end else begin
          e = qpop(i);
          chk($sformatf("rdata%0d", i), rd[i], e.d);
          chk($sformatf("err%0d", i), {31'd0, re[i]}, {31'd0, e.e});
          chk($sformatf("latency%0d", i), cyc - e.acc + 1, lat(i));
        end
      end
    end
  end

  initial begin
    int seen;
    int n;
    logic [31:0] ra;
    logic [1:0]  rz;
    logic [1:0]  rl;
    rst = 3'b111; vld = 1'b0; wr = 1'b0; uns = 1'b0;
    sz = 2'd0; a = '0; wd = '0; sel = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready0", {31'd0, rdy[0]}, 32'd1);
    chk("rst_valid0", {31'd0, rv[0]}, 32'd0);
    chk("rst_rdata0", rd[0], 32'd0);
    chk("rst_err0", {31'd0, re[0]}, 32'd0);
    chk("rst_ready1", {31'd0, rdy[1]}, 32'd1);
    chk("rst_ready2", {31'd0, rdy[2]}, 32'd1);
    rst = 3'b000;
    @(negedge clk);

    // LATENCY=1: word, byte and half accesses
    issue(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF);
    issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0);
    issue(0, 0, SZ_BYTE, 0, 32'h13, 32'h0);
    issue(0, 0, SZ_BYTE, 1, 32'h13, 32'h0);
    issue(0, 0, SZ_HALF, 0, 32'h10, 32'h0);
    issue(0, 0, SZ_HALF, 1, 32'h12, 32'h0);
    issue(0, 1, SZ_BYTE, 0, 32'h11, 32'h55);
    issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0);
    issue(0, 1, SZ_HALF, 0, 32'h11, 32'hAAAA);
    issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0);
    issue(0, 1, SZ_RSVD, 0, 32'h10, 32'h1111);
    issue(0, 1, SZ_WORD, 0, 32'h12, 32'h2222);
    issue(0, 0, SZ_WORD, 0, 32'h11, 32'h0);
    issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0);
    issue(0, 1, SZ_WORD, 0, 32'h8010, 32'h1234);
    issue(0, 0, SZ_WORD, 0, 32'h0010, 32'h0);
    issue(0, 1, SZ_HALF, 0, 32'h22, 32'h8001);
    issue(0, 0, SZ_HALF, 0, 32'h22, 32'h0);

    for (int i = 0; i < 16; i++) begin
      ra = {22'd0, 8'($urandom_range(64, 127)), 2'b00};
      issue(0, 1, SZ_WORD, 0, ra, $urandom);
      rz = 2'($urandom_range(0, 2));
      rl = 2'($urandom_range(0, 3));
      if (rz == SZ_HALF) rl[0] = 1'b0;
      if (rz == SZ_WORD) rl = 2'b00;
      issue(0, 0, rz, 1'($urandom_range(0, 1)), ra | {30'd0, rl}, 32'h0);
    end

    // LATENCY=3: request held for 6 cycles
    issue(1, 1, SZ_WORD, 0, 32'h40, 32'h89ABCDEF);
    sel = 1; wr = 1'b0; sz = SZ_WORD; uns = 1'b0; a = 32'h40;
    wait_rdy(1);
    vld = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ready_l3_c%0d", i), {31'd0, rdy[1]},
          {31'd0, (i % 3) == 0});
      if (rdy[1]) begin
        seen++;
        qpush(1, model(1, 0, SZ_WORD, 0, 32'h40, 32'h0));
      end
      @(negedge clk);
    end
    vld = 1'b0;
    chk("accepts_l3", seen, 2);
    issue(1, 0, SZ_BYTE, 0, 32'h41, 32'h0);

    // LATENCY=4: reset during the second BUSY cycle
    issue(2, 1, SZ_WORD, 0, 32'h20, 32'hCAFEF00D);
    sel = 2; wr = 1'b0; sz = SZ_WORD; uns = 1'b0; a = 32'h20;
    wait_rdy(2);
    vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, rdy[2]}, 32'd1);
    rst[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rv[2]) seen++;
      @(negedge clk);
    end
    chk("no_rsp_after_rst", seen, 0);
    issue(2, 0, SZ_WORD, 0, 32'h20, 32'h0);
    issue(2, 0, SZ_HALF, 0, 32'h22, 32'h0);

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q0.size() + q1.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
